// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings for RV32I loads and stores
//   - FSM state type for lsu_ctrl
//   - byte-lane count of the data bus
package lsu_ctrl_pkg;

    localparam int unsigned LsuLanes = 4;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LsuIdle = 2'd0,
        LsuReq  = 2'd1,
        LsuWait = 2'd2,
        LsuDone = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational byte-lane logic for the load/store unit.
//   is_load_i  : access is a load (else store)
//   funct3_i   : RV32I size/sign encoding
//   addr_lo_i  : byte offset within the word
//   wdata_i    : rs2 value for stores
//   rdata_i    : full word returned by memory
//   err_o      : misaligned address or illegal funct3
//   wstrb_o    : byte-lane write strobes (0 for loads and errors)
//   wdata_o    : lane-replicated store data
//   rdata_o    : extracted and extended load data
module lsu_ctrl_align
    import lsu_ctrl_pkg::*;
(
    input  logic        is_load_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        err_o,
    output logic [LsuLanes-1:0] wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Move the addressed byte/half down to bit 0 before extension.
    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        err_o   = 1'b0;
        wstrb_o = '0;
        wdata_o = wdata_i;
        rdata_o = '0;
        if (is_load_i) begin
            case (funct3_i)
                F3_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
                F3_LBU: rdata_o = {24'h0, shifted[7:0]};
                F3_LH: begin
                    err_o   = addr_lo_i[0];
                    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
                end
                F3_LHU: begin
                    err_o   = addr_lo_i[0];
                    rdata_o = {16'h0, shifted[15:0]};
                end
                F3_LW: begin
                    err_o   = |addr_lo_i;
                    rdata_o = rdata_i;
                end
                default: err_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_SB: begin
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    err_o   = addr_lo_i[0];
                    wstrb_o = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                F3_SW: begin
                    err_o   = |addr_lo_i;
                    wstrb_o = 4'b1111;
                end
                default: err_o = 1'b1;
            endcase
        end
        if (err_o) begin
            wstrb_o = '0;
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit between decode and the data-memory bus.
// One memory transaction per accepted access; completion is a one-cycle
// pulse with formatted load data or a store acknowledge.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : core access handshake (ready only when idle)
//   load, store, funct3 : decoded access kind and size/sign
//   addr, wdata         : byte address and rs2 value
//   out_valid/out_rdata/out_err : completion pulse, data, error flag
//   mem_req_*           : valid/ready request channel to memory
//   mem_resp_valid/mem_resp_rdata : valid-only response channel
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    lsu_state_e        state_q, state_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              idle;
    logic              accept;
    logic              al_is_load;
    logic [2:0]        al_funct3;
    logic [1:0]        al_addr_lo;
    logic              al_err;
    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;

    assign idle   = (state_q == LsuIdle);
    assign accept = idle & in_valid & (load | store);

    // While idle the aligner looks at the live access so an error can be
    // detected on the accept edge; afterwards it sees the latched fields.
    // load and store both high is treated as a load.
    assign al_is_load = idle ? load        : is_load_q;
    assign al_funct3  = idle ? funct3      : funct3_q;
    assign al_addr_lo = idle ? addr[1:0]   : addr_q[1:0];

    lsu_ctrl_align u_align (
        .is_load_i (al_is_load),
        .funct3_i  (al_funct3),
        .addr_lo_i (al_addr_lo),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_resp_rdata),
        .err_o     (al_err),
        .wstrb_o   (al_wstrb),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            LsuIdle: begin
                if (accept) begin
                    is_load_d = load;
                    funct3_d  = funct3;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    rdata_d   = '0;
                    err_d     = al_err;
                    state_d   = al_err ? LsuDone : LsuReq;
                end
            end
            LsuReq: begin
                if (mem_req_ready) begin
                    state_d = LsuWait;
                end
            end
            LsuWait: begin
                if (mem_resp_valid) begin
                    // Stores complete with zero data.
                    rdata_d = is_load_q ? al_rdata : '0;
                    state_d = LsuDone;
                end
            end
            LsuDone: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = LsuIdle;
            end
            default: state_d = LsuIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LsuIdle;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = idle;
    assign out_valid = (state_q == LsuDone);
    assign out_rdata = out_valid ? rdata_q : '0;
    assign out_err   = out_valid & err_q;

    // Request fields come from latched state only, so they hold through REQ.
    assign mem_req_valid = (state_q == LsuReq);
    assign mem_req_addr  = mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_req_wen   = mem_req_valid & ~is_load_q;
    assign mem_req_wdata = mem_req_wen ? al_wdata : '0;
    assign mem_req_wstrb = mem_req_wen ? al_wstrb : 4'b0000;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .load           (load),
        .store          (store),
        .funct3         (funct3),
        .addr           (addr),
        .wdata          (wdata),
        .out_valid      (out_valid),
        .out_rdata      (out_rdata),
        .out_err        (out_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    // Reference model: RV32I load/store semantics expressed in bytes.
    function automatic void ref_model(input bit ld, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [31:0] rsp, output bit err,
                                      output logic [31:0] rd, output logic [3:0] strb,
                                      output logic [31:0] wdo);
        int size;
        int off;
        bit sgn;
        logic [63:0] v;
        off = int'(a[1:0]);
        sgn = (f3[2] == 1'b0);
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        if (size == 0) err = 1'b1;
        else if (f3[2] && (!ld || size == 4)) err = 1'b1;
        else err = (off % size) != 0;
        rd = '0;
        strb = '0;
        wdo = '0;
        if (!err) begin
            if (ld) begin
                v = '0;
                for (int j = 0; j < size; j++) v = v | (64'(rsp[8*(off+j) +: 8]) << (8*j));
                if (sgn && v[8*size-1]) v = v | (~64'h0 << (8*size));
                rd = v[31:0];
            end else begin
                for (int j = 0; j < size; j++) strb[off+j] = 1'b1;
                for (int i = 0; i < 4; i++) wdo[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end
    endfunction

    // Drives one access and observes the whole transaction. Called just after a
    // rising edge; returns just after a rising edge.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int rdly, input int sdly, input logic [31:0] rsp,
                              input bit noise, output int req_cycles,
                              output logic [31:0] q_addr, output logic q_wen,
                              output logic [3:0] q_wstrb, output logic [31:0] q_wdata,
                              output bit stable, output int lat,
                              output logic [31:0] o_rdata, output logic o_err,
                              output bit tail_ok);
        bit in_wait;
        bit go_wait;
        int wait_cnt;
        req_cycles = 0; stable = 1'b1; lat = 0; o_rdata = '0; o_err = 1'b0;
        tail_ok = 1'b0; in_wait = 1'b0; go_wait = 1'b0; wait_cnt = 0;
        q_addr = '0; q_wen = 1'b0; q_wstrb = '0; q_wdata = '0;
        in_valid = 1'b1; load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        in_valid = 1'b0; load = 1'b0; store = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = $urandom;
            if (out_valid) begin
                lat = k;
                o_rdata = out_rdata;
                o_err = out_err;
                break;
            end
            if (mem_req_valid) begin
                if (req_cycles == 0) begin
                    q_addr = mem_req_addr; q_wen = mem_req_wen;
                    q_wstrb = mem_req_wstrb; q_wdata = mem_req_wdata;
                end else if (q_addr !== mem_req_addr || q_wen !== mem_req_wen ||
                             q_wstrb !== mem_req_wstrb || q_wdata !== mem_req_wdata) begin
                    stable = 1'b0;
                end
                req_cycles++;
                mem_req_ready = (req_cycles > rdly);
                if (mem_req_ready) go_wait = 1'b1;
                if (noise) mem_resp_valid = 1'($urandom_range(0, 1));
            end else if (in_wait) begin
                if (wait_cnt == sdly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = rsp;
                end
                wait_cnt++;
            end
            @(posedge clk); #1;
            in_wait = go_wait;
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        tail_ok = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b req_valid=%b, want 1 0 0",
                     in_ready, out_valid, mem_req_valid);
        end else passed++;
        total++;
        if (out_rdata !== 32'h0 || out_err !== 1'b0 || mem_req_addr !== 32'h0 ||
            mem_req_wen !== 1'b0 || mem_req_wstrb !== 4'h0 || mem_req_wdata !== 32'h0) begin
            $display("FAIL reset_data: rdata=%h err=%b addr=%h wen=%b wstrb=%h wdata=%h, want 0",
                     out_rdata, out_err, mem_req_addr, mem_req_wen, mem_req_wstrb,
                     mem_req_wdata);
        end else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL stale_after_reset: out_valid=%b in_ready=%b, want 0 1",
                     out_valid, in_ready);
        end else passed++;
    endtask

    task automatic test_lw();
        int rc, lat; bit stb, tail; logic [31:0] qa, qd, rd; logic qw, er; logic [3:0] qs;
        run_access(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0,
                   rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
        total++;
        if (qa !== 32'h8000_0004 || qs !== 4'h0 || qw !== 1'b0 || rc !== 1) begin
            $display("FAIL lw_req: addr=%h wstrb=%h wen=%b cycles=%0d, want 80000004 0 0 1",
                     qa, qs, qw, rc);
        end else passed++;
        total++;
        if (lat !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || !tail) begin
            $display("FAIL lw_resp: lat=%0d rdata=%h err=%b tail=%b, want 3 deadbeef 0 1",
                     lat, rd, er, tail);
        end else passed++;
    endtask

    task automatic test_lb_lbu();
        int rc, lat; bit stb, tail; logic [31:0] qa, qd, rd; logic qw, er; logic [3:0] qs;
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0,
                   rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
        total++;
        if (rd !== 32'hFFFF_FF80 || er !== 1'b0 || qa !== 32'h0000_1000) begin
            $display("FAIL lb: rdata=%h err=%b addr=%h, want ffffff80 0 00001000", rd, er, qa);
        end else passed++;
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0,
                   rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
        total++;
        if (rd !== 32'h0000_0080 || er !== 1'b0) begin
            $display("FAIL lbu: rdata=%h err=%b, want 00000080 0", rd, er);
        end else passed++;
    endtask

    task automatic test_sh_stall();
        int rc, lat; bit stb, tail; logic [31:0] qa, qd, rd; logic qw, er; logic [3:0] qs;
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 3, 0, 32'h5555_5555,
                   1'b1, rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
        total++;
        if (rc !== 4 || !stb) begin
            $display("FAIL sh_stall_stable: cycles=%0d stable=%b, want 4 1", rc, stb);
        end else passed++;
        total++;
        if (qs !== 4'b1100 || qd !== 32'hABCD_ABCD || qw !== 1'b1 || qa !== 32'h0000_2000) begin
            $display("FAIL sh_fields: wstrb=%b wdata=%h wen=%b addr=%h, want 1100 abcdabcd 1 2000",
                     qs, qd, qw, qa);
        end else passed++;
        total++;
        if (lat !== 6 || rd !== 32'h0 || er !== 1'b0) begin
            $display("FAIL sh_done: lat=%0d rdata=%h err=%b, want 6 0 0", lat, rd, er);
        end else passed++;
    endtask

    task automatic test_errors();
        int rc, lat; bit stb, tail; logic [31:0] qa, qd, rd; logic qw, er; logic [3:0] qs;
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b0,
                   rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
        total++;
        if (rc !== 0 || lat !== 1 || er !== 1'b1 || rd !== 32'h0 || !tail) begin
            $display("FAIL err_misalign: req=%0d lat=%0d err=%b rdata=%h tail=%b, want 0 1 1 0 1",
                     rc, lat, er, rd, tail);
        end else passed++;
        run_access(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b0,
                   rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
        total++;
        if (rc !== 0 || lat !== 1 || er !== 1'b1 || rd !== 32'h0 || !tail) begin
            $display("FAIL err_funct3: req=%0d lat=%0d err=%b rdata=%h tail=%b, want 0 1 1 0 1",
                     rc, lat, er, rd, tail);
        end else passed++;
    endtask

    task automatic test_both_high();
        int rc, lat; bit stb, tail; logic [31:0] qa, qd, rd; logic qw, er; logic [3:0] qs;
        run_access(1'b1, 1'b1, 3'b101, 32'h0000_4002, 32'h1111_1111, 1, 1, 32'h9876_0000,
                   1'b0, rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
        total++;
        if (qw !== 1'b0 || qs !== 4'h0 || rd !== 32'h0000_9876 || lat !== 5) begin
            $display("FAIL both_high: wen=%b wstrb=%h rdata=%h lat=%0d, want 0 0 00009876 5",
                     qw, qs, rd, lat);
        end else passed++;
    endtask

    task automatic test_reset_wait();
        int bad;
        in_valid = 1'b1; load = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h0000_5000;
        @(posedge clk); #1;
        in_valid = 1'b0; load = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL reset_in_wait: in_ready=%b req_valid=%b out_valid=%b, want 1 0 0",
                     in_ready, mem_req_valid, out_valid);
        end else passed++;
        bad = 0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        mem_resp_valid = 1'b0;
        total++;
        if (bad !== 0) begin
            $display("FAIL stale_in_idle: bad cycles=%0d, want 0", bad);
        end else passed++;
    endtask

    task automatic test_non_mem();
        int bad;
        bad = 0;
        in_valid = 1'b1; load = 1'b0; store = 1'b0; funct3 = 3'b010; addr = 32'h0000_6000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        total++;
        if (bad !== 0) begin
            $display("FAIL non_mem: bad cycles=%0d, want 0", bad);
        end else passed++;
    endtask

    task automatic test_random();
        int rc, lat; bit stb, tail; logic [31:0] qa, qd, rd; logic qw, er; logic [3:0] qs;
        logic ld, st; logic [2:0] f3; logic [31:0] a, wd, rsp;
        int rdly, sdly, kind;
        bit x_err; logic [31:0] x_rd, x_wd; logic [3:0] x_strb;
        int x_lat, x_rc;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            ld = (kind != 1);
            st = (kind != 0);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (ld) f3 = 3'($urandom_range(0, 5) == 3 ? 4 : $urandom_range(0, 2));
            else f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            rsp = $urandom;
            rdly = $urandom_range(0, 3);
            sdly = $urandom_range(0, 3);
            ref_model(ld, f3, a, wd, rsp, x_err, x_rd, x_strb, x_wd);
            x_lat = x_err ? 1 : rdly + sdly + 3;
            x_rc = x_err ? 0 : rdly + 1;
            run_access(ld, st, f3, a, wd, rdly, sdly, rsp, 1'b1,
                       rc, qa, qw, qs, qd, stb, lat, rd, er, tail);
            total++;
            if (lat !== x_lat || er !== x_err || rd !== x_rd || rc !== x_rc || !tail) begin
                $display("FAIL rand_done[%0d]: lat=%0d err=%b rdata=%h req=%0d tail=%b, want %0d %b %h %0d 1",
                         n, lat, er, rd, rc, tail, x_lat, x_err, x_rd, x_rc);
            end else passed++;
            if (!x_err) begin
                total++;
                if (qa !== {a[31:2], 2'b00} || qw !== !ld || qs !== x_strb || !stb ||
                    (!ld && qd !== x_wd)) begin
                    $display("FAIL rand_req[%0d]: addr=%h wen=%b wstrb=%b wdata=%h stable=%b, want %h %b %b %h 1",
                             n, qa, qw, qs, qd, stb, {a[31:2], 2'b00}, !ld, x_strb, x_wd);
                end else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; load = 1'b0; store = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_stall();
        test_errors();
        test_both_high();
        test_reset_wait();
        test_non_mem();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
